div_unit: RTL
=============

# div_unit

Multi-cycle radix-2 restoring divider for the MIPS DIV/DIVU instructions. Sits directly upstream of the HI/LO register file in the execute stage. Accepts operands on a start handshake, iterates one quotient bit per cycle, then presents quotient (to LO) and remainder (to HI) with a one-cycle `done` pulse. The execute stage uses `done` as the HI/LO write enable. The unit can be cancelled by a pipeline flush.

## Interface
Parameters:
- none (datapath fixed at 32 bits)

Ports:
- clk  in  1  clock, rising-edge
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  request; operands sampled when `start=1` in IDLE
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU
- dividend  in  32  numerator
- divisor  in  32  denominator
- cancel  in  1  flush; aborts any operation, highest priority
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; result_hi/result_lo valid in that cycle
- result_hi  out  32  remainder (to HI)
- result_lo  out  32  quotient (to LO)

## Operation
- States: IDLE, DIVBY0, CALC, FINISH.
- IDLE with start=1 and cancel=0:
  - If divisor==0, go to DIVBY0.
  - Otherwise capture operands and go to CALC. Capture means: magnitude of each operand when signed_div=1, raw value otherwise. Also latch the quotient-negate flag (dividend sign XOR divisor sign) and the remainder-negate flag (dividend sign), each only when signed_div=1. Clear the 6-bit step counter.
- CALC: one restoring step per cycle:
  - {rem,quo} shifted left 1.
  - Trial subtract of the divisor magnitude using a 33-bit subtract.
  - Quotient bit = 1 when no borrow, and the remainder is replaced by the difference.
  - After the 32nd step, go to FINISH.
- Entering FINISH: load result_lo = quotient and result_hi = remainder. Each is two's-complement negated if its flag is set.
- DIVBY0 → FINISH with result_lo = 32'hFFFF_FFFF and result_hi = dividend (raw, as sampled).
- FINISH: done=1, then IDLE.
- start outside IDLE is ignored. It is not queued.
- cancel=1 in any state: next state is IDLE, no done pulse, and result_hi/result_lo are unchanged. cancel together with start in IDLE: cancel wins and nothing is captured.
- result_hi/result_lo hold their value until the next FINISH load.
- Overflow case: signed 0x8000_0000 / 0xFFFF_FFFF gives result_lo = 0x8000_0000 and result_hi = 0 (natural wrap, no exception).
- Magnitude of 0x8000_0000 is 0x8000_0000 treated as unsigned. This is why the datapath is unsigned internally.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result_hi=0, result_lo=0, counter=0, all flags 0.
- Clock edges:
  - E0 is the edge that samples start.
  - Normal divide: CALC steps happen on E1..E32. FINISH is entered at E32, so done=1 in the cycle between E32 and E33. Results are registered, not combinational.
  - Divide-by-zero: DIVBY0 after E0, FINISH after E1, done=1 between E1 and E2.
- busy rises after E0 and falls after the FINISH edge (done and busy are both high during FINISH).
- A new start is accepted at earliest on the edge that leaves FINISH +1, i.e. when back in IDLE. Back-to-back throughput is 34 cycles.
- Reset asserted mid-operation returns all registers to their reset values immediately (asynchronously). No done pulse is produced.

## Structure
- Shared package entries:
  - state encoding constants (2 bits: IDLE=0, DIVBY0=1, CALC=2, FINISH=3)
  - ZeroWord
  - the DIVBY0 quotient constant 32'hFFFF_FFFF
  - RstEnable
- One natural sub-module: `div_step`, purely combinational. Inputs are rem, quo and divisor; outputs are the next rem and quo. It is instantiated once in CALC.
- The FSM, counter and sign fix-up stay in div_unit.

## Test plan
- Unsigned 100 / 7 (DIVU): done exactly 33 cycles after the start edge; result_lo=14, result_hi=2; busy high for 33 cycles.
- Signed −7 / 2 (0xFFFF_FFF9, 0x2): result_lo=0xFFFF_FFFD (−3), result_hi=0xFFFF_FFFF (−1). Unsigned with the same operands: result_lo=0x7FFF_FFFC, result_hi=1.
- Divide by zero, dividend 0x1234_5678: done 2 cycles after start; result_lo=0xFFFF_FFFF, result_hi=0x1234_5678.
- Signed 0x8000_0000 / 0xFFFF_FFFF: result_lo=0x8000_0000, result_hi=0. Also 0xFFFF_FFFF / 1 unsigned: result_lo=0xFFFF_FFFF, result_hi=0.
- cancel at CALC step 10 then restart with 9/3: no done from the first operation, old results held; second operation gives done 33 cycles later with lo=3, hi=0. A start pulse asserted while busy is ignored.
- resetn low at cycle 20 of a divide: busy, done and results are 0 immediately. After release, a new start works normally.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the MIPS DIV/DIVU unit.
package div_unit_pkg;

  // FSM encoding, 2 bits wide.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVBY0 = 2'd1,
    CALC   = 2'd2,
    FINISH = 2'd3
  } div_state_t;

  // All-zero data word.
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  // Quotient reported for a division by zero.
  localparam logic [31:0] DivBy0Quo = 32'hFFFF_FFFF;

  // Level of resetn that holds the unit in reset.
  localparam logic        RstEnable = 1'b0;

  // Number of restoring steps; the step counter compares against LastStep.
  localparam logic [5:0]  LastStep  = 6'd31;

  // Two's-complement magnitude when the operand is signed and negative.
  // 0x8000_0000 maps onto itself and is then read as unsigned 2^31.
  function automatic logic [31:0] abs_word(input logic [31:0] value,
                                           input logic        is_signed);
    abs_word = (is_signed && value[31]) ? (~value + 32'd1) : value;
  endfunction

  // Conditional two's-complement negation.
  function automatic logic [31:0] neg_if(input logic [31:0] value,
                                         input logic        negate);
    neg_if = negate ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division step: shift {rem,quo} left by one, try to
// subtract the divisor and keep the difference when it does not borrow.
module div_step
  import div_unit_pkg::*;
(
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted_rem;
  logic [32:0] diff;
  logic        borrow;

  // The partial remainder is always below the divisor, so after the shift it
  // fits in 33 bits and a 33-bit subtract tells us whether it reaches the
  // divisor. A set bit 32 in the difference means the subtract borrowed.
  always_comb begin
    shifted_rem = {rem, quo[31]};
    diff        = shifted_rem - {1'b0, divisor};
    borrow      = diff[32];
    rem_next    = borrow ? shifted_rem[31:0] : diff[31:0];
    quo_next    = {quo[30:0], ~borrow};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Quotient goes to LO (result_lo), remainder to HI (result_hi).
//
// Handshake: operands are sampled on the rising edge where start=1, cancel=0
// and the unit is idle (busy=0); start at any other time is dropped, never
// queued. busy stays high from the edge after acceptance up to and including
// the done cycle. done is a single-cycle strobe during which result_hi and
// result_lo already hold the new values; they then stay put until the next
// completed operation. cancel aborts whatever is in flight, suppresses done
// and leaves the result registers untouched.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo
);

  div_state_t  state;
  div_state_t  state_nxt;

  logic [5:0]  step_cnt;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        neg_quo;
  logic        neg_rem;

  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic        accept;
  logic        div_zero;
  logic        last_step;

  div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  // Request qualification shared by the FSM and the operand capture.
  always_comb begin
    accept    = (state == IDLE) && start && !cancel;
    div_zero  = (divisor == ZeroWord);
    last_step = (state == CALC) && (step_cnt == LastStep);
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RstEnable) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs; cancel overrides every transition.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    // A flush in the done cycle also withholds the HI/LO write enable.
    done      = (state == FINISH) && !cancel;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = div_zero ? DIVBY0 : CALC;
        end
      end
      DIVBY0: state_nxt = FINISH;
      CALC: begin
        if (step_cnt == LastStep) begin
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (cancel) begin
      state_nxt = IDLE;
    end
  end

  // Operand capture, sign flags and the iterating remainder/quotient pair.
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RstEnable) begin
      step_cnt <= 6'd0;
      rem_q    <= ZeroWord;
      quo_q    <= ZeroWord;
      dvs_q    <= ZeroWord;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (!cancel) begin
      if (accept) begin
        if (div_zero) begin
          // Raw dividend is parked in quo_q; DIVBY0 forwards it to HI.
          quo_q <= dividend;
        end else begin
          rem_q    <= ZeroWord;
          quo_q    <= abs_word(dividend, signed_div);
          dvs_q    <= abs_word(divisor, signed_div);
          neg_quo  <= signed_div & (dividend[31] ^ divisor[31]);
          neg_rem  <= signed_div & dividend[31];
          step_cnt <= 6'd0;
        end
      end else if (state == CALC) begin
        rem_q    <= rem_nxt;
        quo_q    <= quo_nxt;
        step_cnt <= step_cnt + 6'd1;
      end
    end
  end

  // Result registers, loaded only on the edge that enters FINISH.
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RstEnable) begin
      result_hi <= ZeroWord;
      result_lo <= ZeroWord;
    end else if (!cancel) begin
      if (last_step) begin
        result_lo <= neg_if(quo_nxt, neg_quo);
        result_hi <= neg_if(rem_nxt, neg_rem);
      end else if (state == DIVBY0) begin
        result_lo <= DivBy0Quo;
        result_hi <= quo_q;
      end
    end
  end

endmodule
